jk_bank_driver: RTL
===================

# jk_bank_driver

Controller that drives a bank of WIDTH JK flip-flops from the input side. It accepts target words (or an increment request) over a valid/ready handshake and computes the per-bit J/K excitation from the bank's fed-back state. It applies that excitation for exactly one clock, then checks the bank output against the expected value and keeps mismatch status. It sits between sequencing logic and a register built from JK cells.

## Interface
- WIDTH, 4: number of JK cells in the driven bank (1..32).
- PREFER_TOGGLE, 0: 0 = use set/clear codes for changing bits; 1 = use toggle code for changing bits.
- clk  in  1  single clock; bank cells share this clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  high only in IDLE.
- in_mode  in  1  0 = load in_target; 1 = increment (in_target ignored).
- in_target  in  WIDTH  desired next bank value.
- q_fb  in  WIDTH  current Q outputs of the bank.
- j_out  out  WIDTH  J inputs to bank cells (registered).
- k_out  out  WIDTH  K inputs to bank cells (registered).
- done  out  1  one-cycle pulse when a request finishes its check.
- err  out  1  sticky mismatch flag.
- err_cnt  out  8  saturating mismatch count.
- err_clr  in  1  synchronous clear of err and err_cnt.

## Operation
- Bank cell code {J,K}: 00 hold, 01 force 1, 10 force 0, 11 toggle. This encoding is fixed.
- Per-bit excitation from current c to next n:
  - 0->0 and 1->1: 00.
  - 0->1: 01, or 11 if PREFER_TOGGLE.
  - 1->0: 10, or 11 if PREFER_TOGGLE.
- Target: in_mode=0 uses in_target. in_mode=1 uses (q_fb + 1) mod 2^WIDTH, so all-ones wraps to 0.
- Target and excitation are computed from q_fb sampled at the accept edge.
- FSM: IDLE -> DRIVE -> CHECK -> IDLE.
  - IDLE: in_ready=1, j_out=k_out=0. If in_valid, on the edge: register excitation into j_out/k_out, register expected target, go to DRIVE.
  - DRIVE: j_out/k_out presented to the bank for exactly one cycle. On the edge: j_out/k_out <= 0, go to CHECK.
  - CHECK: compare q_fb with expected. On the edge: done <= 1 for one cycle; on mismatch set err and increment err_cnt (saturating at 255); go to IDLE.
- j_out/k_out are nonzero only in DRIVE. In every other state the bank holds.
- err_clr in a cycle with no CHECK mismatch: err <= 0, err_cnt <= 0.
- err_clr coinciding with a CHECK mismatch: mismatch wins, err=1, err_cnt=1.
- in_valid outside IDLE is ignored; the request must be held until in_ready.

## Timing
- Reset values (asserted asynchronously): state IDLE, in_ready=1, j_out=0, k_out=0, done=0, err=0, err_cnt=0.
- Reset mid-operation: outputs go to reset values immediately and the transaction is dropped with no done. Any bank bit already updated at a DRIVE edge stays as updated.
- Latency, with the accept at edge e0:
  - DRIVE occupies cycle e0..e1; the bank updates at e1.
  - CHECK occupies e1..e2.
  - done is high for e2..e3.
- in_ready is high again after e2. A new request can be accepted at e3 (during the done cycle), giving one request per 3 cycles.
- q_fb must settle within the same cycle. The bank is registered, so its output after e1 is what CHECK samples.

## Test plan
- Reset: assert rst mid-idle -> all outputs at reset values; in_ready=1 with no clock edge required.
- Load, WIDTH=4, PREFER_TOGGLE=0, bank=0000, target 1010 -> in DRIVE j_out=0000, k_out=1010. Bank reads 1010 in CHECK; done pulses at e2; err=0.
- Increment wrap with bank=1111, in_mode=1:
  - PREFER_TOGGLE=0 -> j_out=1111, k_out=0000; bank becomes 0000.
  - PREFER_TOGGLE=1 -> j_out=k_out=1111.
- Fault: bank model with bit0 stuck at 0, load 0001 -> done pulses, err=1, err_cnt=1. Repeat with err_clr asserted in the CHECK cycle -> err=1, err_cnt=1. Clear when idle -> err=0, err_cnt=0.
- Reset during DRIVE -> j_out/k_out drop to 0 the same cycle, no done, in_ready=1 after release.
- in_valid held high with targets 0011, 0110, 1111 -> accepts every 3 cycles, three done pulses, bank ends at 1111, err=0.

Source files
------------

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a bank of JK flip-flops toward a requested value.
// A request is accepted in IDLE, its J/K excitation is applied to the bank
// for exactly one clock (DRIVE), and the bank's fed-back state is then
// compared against the expected value (CHECK). Mismatches are kept in a
// sticky flag and a saturating counter.
// Cell code {J,K}: 00 hold, 01 force 1, 10 force 0, 11 toggle.
module jk_bank_driver #(
    parameter int WIDTH         = 4,
    parameter bit PREFER_TOGGLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] changed;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic             accept;
    logic             mismatch;

    // Target value and per-bit excitation, both derived from the bank state
    // seen at the accept edge. A bit that rises needs code 01 (K set), a bit
    // that falls needs 10 (J set); in toggle mode every changing bit gets 11.
    always_comb begin
        target  = in_mode ? (q_fb + WIDTH'(1)) : in_target;
        changed = q_fb ^ target;
        if (PREFER_TOGGLE) begin
            j_next = changed;
            k_next = changed;
        end else begin
            j_next = changed & ~target;
            k_next = changed & target;
        end
    end

    // Handshake and check qualifiers.
    always_comb begin
        in_ready = (state == IDLE);
        accept   = in_valid && (state == IDLE);
        mismatch = (state == CHECK) && (q_fb != expected);
    end

    // Next-state logic: IDLE -> DRIVE -> CHECK -> IDLE, one cycle per phase.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = DRIVE;
            DRIVE:   state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Excitation registers: loaded only on accept so they are nonzero solely
    // during DRIVE; everywhere else the bank sees hold codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_out    <= '0;
            k_out    <= '0;
            expected <= '0;
        end else begin
            if (accept) begin
                j_out    <= j_next;
                k_out    <= k_next;
                expected <= target;
            end else begin
                j_out    <= '0;
                k_out    <= '0;
            end
        end
    end

    // Completion pulse follows the CHECK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == CHECK);
        end
    end

    // Error status: a mismatch always wins over a simultaneous clear, in which
    // case the count restarts at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_clr) begin
                err_cnt <= 8'd1;
            end else if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if (err_clr) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end
    end

endmodule
